// File: rtl/cpu_step_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_step_controller_pkg
// Brief  : State encodings and widths shared by the step controller files.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_step_controller_pkg;

    localparam int c_cycle_w = 32;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BURST = 2'b10,
        ST_TRAP  = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_step_controller_input_sync.sv
`default_nettype none
// ============================================================================
// Module : cpu_step_controller_input_sync
// Brief  : Multi-flop synchroniser with registered rising-edge detect.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_step_controller_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_level_d;
    logic                   r_rise;

    // Edge is registered so a pin rise shows up SYNC_STAGES+1 clocks later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_chain   <= '0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_chain   <= {r_chain[SYNC_STAGES-2:0], async_in};
            r_level_d <= r_chain[SYNC_STAGES-1];
            r_rise    <= r_chain[SYNC_STAGES-1] & ~r_level_d;
        end
    end

    assign level = r_chain[SYNC_STAGES-1];
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module : cpu_step_controller
// Brief  : Run/step/burst controller issuing single-cycle cpu_en pulses.
// Rev    : 1.0  initial release
// ============================================================================
module cpu_step_controller
    import cpu_step_controller_pkg::*;
#(
    parameter int DIV_COUNT   = 25000000,
    parameter int BURST_LEN   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run_sw,
    input  logic                 step_btn,
    input  logic                 burst_btn,
    input  logic                 halt_req,
    output logic                 cpu_en,
    output logic [1:0]           state,
    output logic                 trapped,
    output logic [c_cycle_w-1:0] cycle_count
);

    localparam int c_tick_w  = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam int c_burst_w = $clog2(BURST_LEN + 1);

    logic                 w_run_level;
    logic                 w_step_rise;
    logic                 w_burst_rise;
    logic                 w_tick;

    state_t               r_state;
    logic                 r_cpu_en;
    logic                 r_trapped;
    logic [c_cycle_w-1:0] r_cycle_count;
    logic [c_tick_w-1:0]  r_tick_cnt;
    logic [c_burst_w-1:0] r_remaining;

    cpu_step_controller_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (
        .clock    (clock),
        .reset    (reset),
        .async_in (run_sw),
        .level    (w_run_level),
        .rise     ()
    );

    cpu_step_controller_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
        .clock    (clock),
        .reset    (reset),
        .async_in (step_btn),
        .level    (),
        .rise     (w_step_rise)
    );

    cpu_step_controller_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_burst (
        .clock    (clock),
        .reset    (reset),
        .async_in (burst_btn),
        .level    (),
        .rise     (w_burst_rise)
    );

    assign w_tick = (r_tick_cnt == c_tick_w'(DIV_COUNT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_HALT;
            r_cpu_en      <= 1'b0;
            r_trapped     <= 1'b0;
            r_cycle_count <= '0;
            r_tick_cnt    <= '0;
            r_remaining   <= '0;
        end else begin
            r_cpu_en      <= 1'b0;
            r_cycle_count <= r_cycle_count + {{(c_cycle_w-1){1'b0}}, r_cpu_en};

            if (r_state == ST_RUN || r_state == ST_BURST)
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            else
                r_tick_cnt <= '0;

            // A trap request overrides any tick or step edge in the same cycle.
            if (halt_req && r_state != ST_TRAP) begin
                r_state   <= ST_TRAP;
                r_trapped <= 1'b1;
            end else begin
                case (r_state)
                    ST_TRAP: begin
                        if (w_step_rise) begin
                            r_state   <= ST_HALT;
                            r_trapped <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (!w_run_level)
                            r_state <= ST_HALT;
                        else if (w_tick)
                            r_cpu_en <= 1'b1;
                    end
                    ST_HALT: begin
                        if (w_run_level) begin
                            r_state    <= ST_RUN;
                            r_tick_cnt <= '0;
                        end else if (w_burst_rise) begin
                            r_state     <= ST_BURST;
                            r_remaining <= c_burst_w'(BURST_LEN);
                            r_tick_cnt  <= '0;
                        end else if (w_step_rise) begin
                            r_cpu_en <= 1'b1;
                        end
                    end
                    ST_BURST: begin
                        if (w_tick) begin
                            r_cpu_en    <= 1'b1;
                            r_remaining <= r_remaining - 1'b1;
                            if (r_remaining == c_burst_w'(1))
                                r_state <= ST_HALT;
                        end
                    end
                    default: r_state <= ST_HALT;
                endcase
            end
        end
    end

    assign cpu_en      = r_cpu_en;
    assign state       = r_state;
    assign trapped     = r_trapped;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_step_controller
// Brief  : Scoreboard bench for the run/step/burst controller.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cpu_step_controller;

    localparam logic [1:0] c_halt  = 2'b00;
    localparam logic [1:0] c_run   = 2'b01;
    localparam logic [1:0] c_burst = 2'b10;
    localparam logic [1:0] c_trap  = 2'b11;

    typedef struct {
        int          cyc;
        logic [1:0]  st;
        logic [31:0] cnt;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        run_sw;
    logic        step_btn;
    logic        burst_btn;
    logic        halt_req;
    logic        cpu_en;
    logic [1:0]  state;
    logic        trapped;
    logic [31:0] cycle_count;

    int          cyc;
    int          tests;
    int          fails;
    logic [31:0] exp_cnt;
    exp_t        sb[$];

    cpu_step_controller #(
        .DIV_COUNT   (4),
        .BURST_LEN   (3),
        .SYNC_STAGES (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run_sw      (run_sw),
        .step_btn    (step_btn),
        .burst_btn   (burst_btn),
        .halt_req    (halt_req),
        .cpu_en      (cpu_en),
        .state       (state),
        .trapped     (trapped),
        .cycle_count (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor: every cpu_en pulse must match the next scoreboard entry.
    always @(negedge clock) begin
        if (reset === 1'b1 && cpu_en === 1'b1) begin
            tests = tests + 1;
            if (sb.size() == 0) begin
                fails = fails + 1;
                $display("FAIL pulse: unexpected cpu_en at cycle %0d state %b count %h, required none",
                         cyc, state, cycle_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.cyc || state !== e.st || cycle_count !== e.cnt) begin
                    fails = fails + 1;
                    $display("FAIL pulse: got cycle %0d state %b count %h, required cycle %0d state %b count %h",
                             cyc, state, cycle_count, e.cyc, e.st, e.cnt);
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_pulse(input int at, input logic [1:0] st);
        exp_t e;
        e.cyc = at;
        e.st  = st;
        e.cnt = exp_cnt;
        sb.push_back(e);
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        int c;
        tests     = 0;
        fails     = 0;
        exp_cnt   = 32'd0;
        reset     = 1'b0;
        run_sw    = 1'b0;
        step_btn  = 1'b0;
        burst_btn = 1'b0;
        halt_req  = 1'b0;

        // Reset and idle
        wait_clks(3);
        reset = 1'b1;
        wait_clks(10);
        check("reset_state",   {30'd0, state}, 32'd0);
        check("reset_count",   cycle_count, 32'd0);
        check("reset_trapped", {31'd0, trapped}, 32'd0);
        check("reset_cpu_en",  {31'd0, cpu_en}, 32'd0);

        // Single step in HALT
        c = cyc;
        push_pulse(c + 4, c_halt);
        step_btn = 1'b1;
        wait_clks(5);
        step_btn = 1'b0;
        wait_clks(5);
        check("step_count", cycle_count, 32'd1);

        // Free run, then drop run_sw on the cycle a tick would fire
        c = cyc;
        for (int k = 0; k < 5; k++) push_pulse(c + 7 + 4 * k, c_run);
        run_sw = 1'b1;
        wait_clks(5);
        check("run_state", {30'd0, state}, {30'd0, c_run});
        wait_clks(19);
        run_sw = 1'b0;
        wait_clks(8);
        check("run_stop_state", {30'd0, state}, {30'd0, c_halt});
        check("run_count", cycle_count, 32'd6);

        // Burst with a step edge arriving mid-burst
        c = cyc;
        push_pulse(c + 8,  c_burst);
        push_pulse(c + 12, c_burst);
        push_pulse(c + 16, c_halt);
        burst_btn = 1'b1;
        wait_clks(3);
        burst_btn = 1'b0;
        wait_clks(2);
        check("burst_state", {30'd0, state}, {30'd0, c_burst});
        wait_clks(1);
        step_btn = 1'b1;
        wait_clks(3);
        step_btn = 1'b0;
        wait_clks(11);
        check("burst_end_state", {30'd0, state}, {30'd0, c_halt});
        check("burst_count", cycle_count, 32'd9);

        // Trap on a tick cycle, ignored inputs, step acknowledge
        c = cyc;
        push_pulse(c + 7, c_run);
        run_sw = 1'b1;
        wait_clks(10);
        halt_req = 1'b1;
        wait_clks(1);
        halt_req = 1'b0;
        check("trap_state",   {30'd0, state}, {30'd0, c_trap});
        check("trap_flag",    {31'd0, trapped}, 32'd1);
        run_sw = 1'b0;
        wait_clks(4);
        run_sw = 1'b1;
        wait_clks(4);
        run_sw = 1'b0;
        burst_btn = 1'b1;
        wait_clks(3);
        burst_btn = 1'b0;
        wait_clks(8);
        check("trap_hold_state", {30'd0, state}, {30'd0, c_trap});
        check("trap_hold_flag",  {31'd0, trapped}, 32'd1);
        step_btn = 1'b1;
        wait_clks(3);
        step_btn = 1'b0;
        wait_clks(3);
        check("ack_state",   {30'd0, state}, {30'd0, c_halt});
        check("ack_flag",    {31'd0, trapped}, 32'd0);
        check("trap_count",  cycle_count, 32'd10);

        // Cycle counter wrap
        force dut.r_cycle_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycle_count;
        exp_cnt = 32'hFFFF_FFFE;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            c = cyc;
            push_pulse(c + 4, c_halt);
            step_btn = 1'b1;
            wait_clks(5);
            step_btn = 1'b0;
            wait_clks(3);
            check(k == 0 ? "wrap_ffffffff" : "wrap_zero", cycle_count, exp_cnt);
        end

        // Asynchronous reset while a burst pulse is on the output
        c = cyc;
        push_pulse(c + 8,  c_burst);
        push_pulse(c + 12, c_burst);
        burst_btn = 1'b1;
        wait_clks(3);
        burst_btn = 1'b0;
        wait_clks(9);
        #2;
        reset = 1'b0;
        #1;
        check("async_cpu_en",  {31'd0, cpu_en}, 32'd0);
        check("async_state",   {30'd0, state}, 32'd0);
        check("async_count",   cycle_count, 32'd0);
        check("async_trapped", {31'd0, trapped}, 32'd0);
        exp_cnt = 32'd0;
        @(negedge clock);
        reset = 1'b1;
        wait_clks(10);
        check("post_reset_state", {30'd0, state}, 32'd0);
        check("post_reset_count", cycle_count, 32'd0);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL missing_pulse: got none, required pulse at cycle %0d state %b", e.cyc, e.st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
